signed_mul_seq: RTL and testbench

//  Multi-cycle 32x32 multiplier sequencer for the ALU. Sign handling reuses one shared
//  two's-complement unit (Comp), time-multiplexed across operand A, operand B and the result.
//  The magnitude product comes from a shift-add loop on a CSA32 adder.

---
 rtl/smul_pkg.sv | 18 +
 rtl/signed_mul_seq_comp.sv | 13 +
 rtl/signed_mul_seq_csa.sv | 18 +
 rtl/signed_mul_seq.sv | 143 ++++++++++++++
 tb/tb_signed_mul_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/smul_pkg.sv
// Shared types and constants for the sequential
// 32x32 signed/unsigned multiplier.
package smul_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEGA,
    S_NEGB,
    S_MUL,
    S_NEGP,
    S_DONE
  } state_t;

endpackage

// File: rtl/signed_mul_seq_comp.sv
// Shared two's-complement unit: passes the input
// through, or negates it when addsub is set.
module signed_mul_seq_comp
  import smul_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  input  logic             addsub,
  output logic [WIDTH-1:0] dout
);

  assign dout = addsub ? (~din + 1'b1) : din;

endmodule

// File: rtl/signed_mul_seq_csa.sv
// 32-bit accumulate stage: acc + (en ? addend : 0)
// with the carry-out kept as a 33rd bit.
module signed_mul_seq_csa
  import smul_pkg::*;
(
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] addend,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] op;

  assign op = en ? addend : '0;
  assign {cout, sum} = {1'b0, acc} + {1'b0, op};

endmodule

// File: rtl/signed_mul_seq.sv
// Multi-cycle 32x32 multiplier: sign-magnitude
// around a shift-add loop, one shared negator.
module signed_mul_seq
  import smul_pkg::*;
(
  input  logic        clk_smul,
  input  logic        rstn_smul,
  input  logic        start_smul,
  input  logic        signed_smul,
  input  logic [31:0] a_smul,
  input  logic [31:0] b_smul,
  output logic        busy_smul,
  output logic        done_smul,
  output logic [31:0] product_smul,
  output logic        ovf_smul
);

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg;
  logic             signed_q;

  logic [WIDTH-1:0] comp_in;
  logic             comp_as;
  logic [WIDTH-1:0] comp_out;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_nxt;

  // Negator input select, decoded from state only
  always_comb begin
    comp_in = acc_lo;
    comp_as = neg;
    case (state)
      S_NEGA: begin
        comp_in = mcand;
        comp_as = signed_q & mcand[WIDTH-1];
      end
      S_NEGB: begin
        comp_in = acc_lo;
        comp_as = signed_q & acc_lo[WIDTH-1];
      end
      default: begin
        comp_in = acc_lo;
        comp_as = neg;
      end
    endcase
  end

  signed_mul_seq_comp u_comp (
    .din    (comp_in),
    .addsub (comp_as),
    .dout   (comp_out)
  );

  signed_mul_seq_csa u_csa (
    .acc    (acc_hi),
    .addend (mcand),
    .en     (acc_lo[0]),
    .sum    (sum),
    .cout   (cout)
  );

  // Range check on the final magnitude
  always_comb begin
    ovf_nxt = |acc_hi;
    if (signed_q) begin
      ovf_nxt = (|acc_hi) |
        (acc_lo[WIDTH-1] &
         ~(neg & (acc_lo == MIN_NEG)));
    end
  end

  // Sequencer with registered handshake/result
  always_ff @(posedge clk_smul or negedge rstn_smul) begin
    if (!rstn_smul) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mcand        <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      neg          <= 1'b0;
      signed_q     <= 1'b0;
      busy_smul    <= 1'b0;
      done_smul    <= 1'b0;
      product_smul <= '0;
      ovf_smul     <= 1'b0;
    end else begin
      done_smul <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_smul) begin
            mcand     <= a_smul;
            acc_lo    <= b_smul;
            signed_q  <= signed_smul;
            neg       <= signed_smul &
                         (a_smul[31] ^ b_smul[31]);
            busy_smul <= 1'b1;
            state     <= S_NEGA;
          end
        end
        S_NEGA: begin
          mcand <= comp_out;
          state <= S_NEGB;
        end
        S_NEGB: begin
          acc_lo <= comp_out;
          acc_hi <= '0;
          cnt    <= '0;
          state  <= S_MUL;
        end
        S_MUL: begin
          acc_hi <= {cout, sum[WIDTH-1:1]};
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= S_NEGP;
          end
        end
        S_NEGP: begin
          product_smul <= comp_out;
          ovf_smul     <= ovf_nxt;
          done_smul    <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          busy_smul <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mul_seq.sv
// Self-checking bench for signed_mul_seq:
// timing/result model plus directed vectors.
module tb_signed_mul_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signed_mul_seq dut (
    .clk_smul     (clk),
    .rstn_smul    (rstn),
    .start_smul   (start),
    .signed_smul  (sgn),
    .a_smul       (a),
    .b_smul       (b),
    .busy_smul    (busy),
    .done_smul    (done),
    .product_smul (prod),
    .ovf_smul     (ovf)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Arithmetic reference for one operation
  function automatic void calc(
    input  logic        s,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] p,
    output logic        o);
    logic signed [63:0] sp;
    logic [63:0]        up;
    if (s) begin
      sp = $signed({{32{x[31]}}, x}) *
           $signed({{32{y[31]}}, y});
      p  = sp[31:0];
      o  = (sp > 64'sd2147483647) ||
           (sp < -64'sd2147483648);
    end else begin
      up = {32'd0, x} * {32'd0, y};
      p  = up[31:0];
      o  = |up[63:32];
    end
  endfunction

  // Cycle model: edges since acceptance
  int          m_cnt = -1;
  logic [31:0] m_prod = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] pend_p;
  logic        pend_o;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  = -1;
      m_prod = '0;
      m_ovf  = 1'b0;
    end else if (m_cnt < 0) begin
      if (start === 1'b1) begin
        m_cnt = 0;
        calc(sgn, a, b, pend_p, pend_o);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 35) begin
        m_prod = pend_p;
        m_ovf  = pend_o;
      end
      if (m_cnt == 36) m_cnt = -1;
    end
  end

  // Compare DUT outputs against the model each cycle
  always @(negedge clk) begin
    chk("m_busy", 64'(busy), 64'(m_cnt >= 0));
    chk("m_done", 64'(done), 64'(m_cnt == 35));
    chk("m_prod", 64'(prod), 64'(m_prod));
    chk("m_ovf",  64'(ovf),  64'(m_ovf));
  end

  task automatic run_op(input string nm,
                        input logic s,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] ep,
                        input logic eo);
    int  n;
    bit  got;
    @(negedge clk);
    sgn = s; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    chk({nm, "_lat"}, 64'(n), 64'd35);
    chk({nm, "_p"}, 64'(prod), 64'(ep));
    chk({nm, "_o"}, 64'(ovf), 64'(eo));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int  n;
    bit  got;
    int  gap;
    rstn = 1'b0; start = 1'b0; sgn = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", 64'(prod), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_op("u7x6", 0, 32'd7, 32'd6, 32'h2A, 0);
    run_op("sm3x5", 1, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFF1, 0);
    run_op("sm4xm4", 1, 32'hFFFFFFFC, 32'hFFFFFFFC,
           32'h10, 0);
    run_op("smin_m1", 1, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1);
    run_op("umax_sq", 0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h1, 1);
    run_op("s_negmin", 1, 32'hFFFF0000, 32'h8000,
           32'h80000000, 0);
    run_op("s_posmin", 1, 32'h10000, 32'h8000,
           32'h80000000, 1);
    run_op("s_zero_neg", 1, 32'd0, 32'hFFFFFFFB,
           32'h0, 0);
    run_op("u_hi", 0, 32'h80000000, 32'd2,
           32'h0, 1);
    run_op("s_m1_m1", 1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h1, 0);

    // start pulses while busy are ignored
    @(negedge clk);
    sgn = 1; a = 32'hFFFFFFFD; b = 32'd5; start = 1;
    @(posedge clk);
    #1 start = 0;
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      start = (n == 5 || n == 20);
      a = 32'd1; b = 32'd1; sgn = 0;
      if (done) got = 1;
    end
    start = 0;
    chk("ign_lat", 64'(n), 64'd35);
    chk("ign_p", 64'(prod), 64'hFFFFFFF1);
    chk("ign_o", 64'(ovf), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_idle", 64'(busy), 64'd0);

    // start held: back-to-back with an IDLE gap
    @(negedge clk);
    sgn = 0; a = 32'd3; b = 32'd11; start = 1;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    chk("held_lat1", 64'(n), 64'd35);
    chk("held_p1", 64'(prod), 64'd33);
    gap = 0; got = 0;
    while (!got && gap < 60) begin
      @(posedge clk); #1;
      gap++;
      if (done) got = 1;
    end
    start = 0;
    chk("held_gap", 64'(gap), 64'd37);
    chk("held_p2", 64'(prod), 64'd33);
    repeat (2) @(posedge clk);
    #1;
    chk("held_idle", 64'(busy), 64'd0);

    // async reset mid-MUL discards the op
    @(negedge clk);
    sgn = 1; a = 32'd100; b = 32'd200; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (12) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_prod", 64'(prod), 64'd0);
    chk("ar_ovf",  64'(ovf),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    got = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) got = 1;
    end
    chk("ar_nodone", 64'(got), 64'd0);
    run_op("post_rst", 0, 32'd9, 32'd9, 32'd81, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
